// File: rtl/sat_accum_mc.sv
// Multi-channel saturating accumulator: valid/ready sample in, clamped running sum per channel out.
// Latency: a sample accepted at edge N updates its channel and appears on out_* from edge N to N+1.
// Backpressure: in_ready drops only during a clear-all sweep (NCH cycles); out_* has no backpressure.
module sat_accum_mc #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16,
    parameter int NCH   = 4,
    parameter int CH_W  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    input  logic             clr,
    input  logic [CH_W-1:0]  clr_ch,
    input  logic             clr_all,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat,
    output logic [NCH-1:0]   sat_flags
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NCH - 1);

    state_t           state_q;
    logic [CH_W-1:0]  idx_q;
    logic             rdy_q;

    logic [ACC_W-1:0] acc_q [NCH];
    logic [ACC_W-1:0] acc_d [NCH];
    logic [NCH-1:0]   sat_q;
    logic [NCH-1:0]   sat_d;

    logic             out_valid_q;
    logic [CH_W-1:0]  out_ch_q;
    logic [ACC_W-1:0] out_sum_q;
    logic             out_sat_q;

    logic             accept;
    logic             sweeping;
    logic             clr_eff;
    logic             clr_hit;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   data_ext;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] res_d;
    logic             ovf_d;

    assign in_ready  = rdy_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;
    assign sat_flags = sat_q;

    // Read-modify-write datapath: a clear on the same channel makes the add start from zero.
    always_comb begin
        accept   = in_valid & rdy_q;
        sweeping = (state_q == ST_SWEEP);
        clr_eff  = clr & ~sweeping;
        clr_hit  = clr_eff & (clr_ch == in_ch);
        base     = clr_hit ? '0 : acc_q[in_ch];
        data_ext = '0;
        sum_ext  = '0;
        res_d    = '0;
        ovf_d    = 1'b0;
        if (in_signed) begin
            data_ext = {{(ACC_W + 1 - IN_W){in_data[IN_W-1]}}, in_data};
            sum_ext  = {base[ACC_W-1], base} + data_ext;
            // True sum fits ACC_W+1 bits; it is out of range when the top two bits disagree.
            ovf_d    = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
            if (ovf_d) begin
                res_d = sum_ext[ACC_W] ? SMIN : SMAX;
            end else begin
                res_d = sum_ext[ACC_W-1:0];
            end
        end else begin
            data_ext = {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
            sum_ext  = {1'b0, base} + data_ext;
            ovf_d    = sum_ext[ACC_W];
            res_d    = ovf_d ? '1 : sum_ext[ACC_W-1:0];
        end
    end

    // Per-channel next state: sweep zeroing, then sample update, then standalone clear.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            acc_d[i] = acc_q[i];
            sat_d[i] = sat_q[i];
            if (sweeping && (idx_q == CH_W'(i))) begin
                acc_d[i] = '0;
                sat_d[i] = 1'b0;
            end else if (accept && (in_ch == CH_W'(i))) begin
                acc_d[i] = res_d;
                sat_d[i] = (sat_q[i] & ~clr_hit) | ovf_d;
            end else if (clr_eff && (clr_ch == CH_W'(i))) begin
                acc_d[i] = '0;
                sat_d[i] = 1'b0;
            end
        end
    end

    // Accumulator and sticky flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
            end
            sat_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= acc_d[i];
            end
            sat_q <= sat_d;
        end
    end

    // Clear-all FSM; in_ready is registered so it tracks the state one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_all) begin
                        state_q <= ST_SWEEP;
                        idx_q   <= '0;
                        rdy_q   <= 1'b0;
                    end else begin
                        rdy_q   <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (idx_q == LAST_CH) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                        rdy_q   <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    // Informational update stream: one beat per accepted sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                out_ch_q  <= in_ch;
                out_sum_q <= res_d;
                out_sat_q <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_sat_accum_mc.sv
// Directed bench for sat_accum_mc with a queue-based scoreboard.
// Stimulus pushes the expected update; a monitor pops on every out_valid.
// Waits on in_ready are bounded; a global watchdog ends a stuck run.
module tb_sat_accum_mc;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] sum;
        logic        sat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ch;
    logic [7:0]  in_data;
    logic        in_signed;
    logic        clr;
    logic [1:0]  clr_ch;
    logic        clr_all;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] out_sum;
    logic        out_sat;
    logic [3:0]  sat_flags;

    int   checks;
    int   errors;
    exp_t exp_q[$];

    sat_accum_mc #(.IN_W(8), .ACC_W(16), .NCH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .in_signed (in_signed),
        .clr       (clr),
        .clr_ch    (clr_ch),
        .clr_all   (clr_all),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_sum   (out_sum),
        .out_sat   (out_sat),
        .sat_flags (sat_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one sample, queue its expected update, hold until accepted.
    task automatic send(input logic [1:0] ch, input logic [7:0] d, input logic sg,
                        input logic [15:0] es, input logic esat);
        int n;
        exp_t e;
        n         = 0;
        in_valid  = 1'b1;
        in_ch     = ch;
        in_data   = d;
        in_signed = sg;
        e.ch  = ch;
        e.sum = es;
        e.sat = esat;
        exp_q.push_back(e);
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        int   n;
        int   v;
        exp_t e;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_ch     = '0;
        in_data   = '0;
        in_signed = 1'b0;
        clr       = 1'b0;
        clr_ch    = '0;
        clr_all   = 1'b0;

        // Scoreboard monitor
        fork
            forever begin
                @(negedge clk);
                if (rst && out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got ch %0h sum %0h sat %0b expected no update",
                                 out_ch, out_sum, out_sat);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_update", {13'b0, out_ch, out_sum, out_sat}, {13'b0, e});
                    end
                end
            end
        join_none

        // Reset state
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_sum", {16'b0, out_sum}, 32'd0);
        chk("rst_sat_flags", {28'b0, sat_flags}, 32'd0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);

        // Unsigned saturation on channel 0
        for (int i = 1; i <= 257; i++) begin
            send(2'd0, 8'hFF, 1'b0, 16'(255 * i), 1'b0);
        end
        chk("u_no_flag", {28'b0, sat_flags}, 32'h0);
        send(2'd0, 8'h01, 1'b0, 16'hFFFF, 1'b1);
        idle();
        chk("u_flag", {28'b0, sat_flags}, 32'h1);

        // Signed saturation on channel 1
        for (int i = 1; i <= 256; i++) begin
            send(2'd1, 8'h80, 1'b1, 16'(-(128 * i)), 1'b0);
        end
        chk("s_no_flag", {28'b0, sat_flags}, 32'h1);
        send(2'd1, 8'h80, 1'b1, 16'h8000, 1'b1);
        send(2'd1, 8'h7F, 1'b1, 16'h807F, 1'b0);
        idle();
        chk("s_flag", {28'b0, sat_flags}, 32'h3);

        // Channel isolation
        for (int k = 1; k <= 5; k++) begin
            send(2'd2, 8'h10, 1'b0, 16'(16 * k), 1'b0);
            send(2'd3, 8'h03, 1'b0, 16'(3 * k), 1'b0);
        end
        send(2'd0, 8'h00, 1'b0, 16'hFFFF, 1'b0);
        send(2'd1, 8'h00, 1'b1, 16'h807F, 1'b0);
        idle();

        // Clear colliding with a sample, then clear beside a sample
        clr    = 1'b1;
        clr_ch = 2'd2;
        send(2'd2, 8'h07, 1'b0, 16'h0007, 1'b0);
        clr_ch = 2'd0;
        send(2'd3, 8'h01, 1'b0, 16'h0010, 1'b0);
        clr    = 1'b0;
        idle();
        chk("clr_flags", {28'b0, sat_flags}, 32'h2);
        send(2'd0, 8'h05, 1'b0, 16'h0005, 1'b0);
        idle();

        // Clear-all during streaming: sample on the clr_all edge still processed
        clr_all = 1'b1;
        send(2'd2, 8'h01, 1'b0, 16'h0008, 1'b0);
        clr_all = 1'b0;
        chk("sweep_ready_low", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_ch    = 2'd3;
        in_data  = 8'h02;
        in_signed = 1'b0;
        e.ch  = 2'd3;
        e.sum = 16'h0002;
        e.sat = 1'b0;
        exp_q.push_back(e);
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sweep_len", n, 32'd4);
        chk("sweep_flags", {28'b0, sat_flags}, 32'h0);
        @(posedge clk);
        #1;
        send(2'd0, 8'h01, 1'b0, 16'h0001, 1'b0);
        send(2'd1, 8'h01, 1'b1, 16'h0001, 1'b0);
        send(2'd2, 8'h01, 1'b0, 16'h0001, 1'b0);
        idle();

        // Saturate channel 3 so reset has a flag to wipe
        for (int i = 1; i <= 257; i++) begin
            v = 2 + 255 * i;
            if (v > 65535) begin
                send(2'd3, 8'hFF, 1'b0, 16'hFFFF, 1'b1);
            end else begin
                send(2'd3, 8'hFF, 1'b0, 16'(v), 1'b0);
            end
        end
        idle();
        chk("ch3_flag", {28'b0, sat_flags}, 32'h8);

        // Asynchronous reset in the middle of a sweep
        clr_all = 1'b1;
        @(posedge clk);
        #1;
        clr_all = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_sweep_flags", {28'b0, sat_flags}, 32'h8);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_sat_flags", {28'b0, sat_flags}, 32'h0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("arst_out_sum", {16'b0, out_sum}, 32'd0);
        chk("arst_out_ch", {30'b0, out_ch}, 32'd0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rerelease_in_ready", {31'b0, in_ready}, 32'd1);
        send(2'd1, 8'h01, 1'b0, 16'h0001, 1'b0);
        send(2'd3, 8'h01, 1'b1, 16'h0001, 1'b0);
        idle();
        chk("post_rst_flags", {28'b0, sat_flags}, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sat_accum_mc.md
# sat_accum_mc

Multi-channel saturating accumulator with a valid/ready sample input, per-sample unsigned/signed mode, per-channel and global clear, and sticky saturation flags. Each accepted sample is added into the selected channel's register, clamped at the representable bounds. The updated sum is streamed out one cycle later. It sits behind sample producers (ADC, counters, DSP taps) wherever several independent running totals share one datapath.

## Interface
- IN_W, default 8: input sample width.
- ACC_W, default 16: accumulator width per channel; must be greater than IN_W.
- NCH, default 4: channel count, at least 2.
- CH_W, default $clog2(NCH): channel index width.

- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: sample present.
- in_ready, output, 1: block can accept a sample.
- in_ch, input, CH_W: target channel.
- in_data, input, IN_W: sample.
- in_signed, input, 1: 1 means the sample and the target channel are treated as two's complement.
- clr, input, 1: clear one channel, given by clr_ch.
- clr_ch, input, CH_W: channel to clear.
- clr_all, input, 1: pulse that starts a sweep clearing every channel.
- out_valid, output, 1: out_sum/out_ch hold a fresh update.
- out_ch, output, CH_W: channel of the update.
- out_sum, output, ACC_W: post-update value of out_ch.
- out_sat, output, 1: this update saturated.
- sat_flags, output, NCH: sticky per-channel saturation flags.

## Operation
- Accept: a sample is accepted at an edge where in_valid, in_ready and rst are all high.
- Sum width: the sum is computed in ACC_W+1 bits.
- Unsigned mode: acc + zero-extended in_data. A result above 2^ACC_W−1 is clamped to all-ones.
- Signed mode: sign-extended acc + sign-extended in_data. A result above 2^(ACC_W−1)−1 is clamped to 0x7FFF…; a result below −2^(ACC_W−1) is clamped to 0x800….
- Mode handling: the mode is taken per sample. Stored values are never reinterpreted or converted on a mode change.
- Saturation: any clamp sets sat_flags[in_ch] and out_sat for that update. A result landing exactly on a bound is not saturation.
- Single-channel clear: clr zeroes acc[clr_ch] and sat_flags[clr_ch] at the edge. It does not drop in_ready.
- Clear colliding with a sample on the same channel: clear-then-add.
  - acc becomes the extended in_data.
  - The flag is cleared.
  - out_valid fires with that value.
- Clear and a sample on different channels: both take effect in the same edge.
- Clear-all FSM, IDLE: in_ready is 1. clr_all moves the FSM to SWEEP with idx=0. Any sample accepted in that same edge is processed normally.
- Clear-all FSM, SWEEP: in_ready is 0.
  - Each cycle zeroes acc[idx] and sat_flags[idx], then increments idx.
  - After idx=NCH−1 the FSM returns to IDLE.
  - SWEEP lasts exactly NCH cycles.
  - clr and clr_all are ignored during SWEEP.
- Sample dropped by SWEEP: a sample arriving while in_ready is 0 is not accepted. The producer holds it.
- Output stream: out_* carries no backpressure and is informational only.

## Timing
- Reset (rst low, asynchronous), every output forced to:
  - all acc = 0, sat_flags = 0;
  - out_valid = 0, out_sum = 0, out_ch = 0, out_sat = 0;
  - FSM = IDLE, in_ready = 0.
- Reset release: in_ready is 1 from the first edge after rst goes high.
- Reset mid-SWEEP: aborts the sweep. Everything is zero after release.
- Latency: a sample accepted at edge N updates acc and drives out_valid/out_sum/out_ch/out_sat from edge N until edge N+1.
- out_valid: low in any cycle without an accepted sample.
- Throughput: back-to-back samples on the same channel, one per cycle, with no bubbles. The accumulation path is single-cycle read-modify-write.
- in_ready: registered from the FSM state. It falls the cycle after clr_all is sampled and rises again NCH cycles later.
- sat_flags: visible the cycle after the saturating edge. It is only cleared by clr, clr_all or rst.

## Test plan
- Unsigned saturation, channel 0, in_signed=0:
  - 257 samples of 0xFF give out_sum=0xFFFF with out_sat=0 and sat_flags=0.
  - One further sample of 0x01 gives out_sum=0xFFFF, out_sat=1 and sat_flags=4'b0001.
- Signed saturation, channel 1, in_signed=1:
  - 256 samples of 0x80 give 0x8000 with no flag.
  - The next 0x80 gives 0x8000 with out_sat=1 and sat_flags[1]=1.
  - A following 0x7F gives 0x807F.
- Channel isolation: interleave 0x10 into channel 2 and 0x03 into channel 3, 5 times each. Final out_sum is 0x0050 on channel 2 and 0x000F on channel 3. Channels 0 and 1 are unchanged.
- Clear collision:
  - With acc[2]=0x0050, clr on channel 2 plus a sample of 0x07 on channel 2 gives out_sum=0x0007.
  - clr on channel 0 together with a sample on channel 3 clears channel 0 and accumulates channel 3.
- clr_all during streaming:
  - in_ready is low for exactly 4 cycles.
  - Held samples are not lost and are accepted after the sweep.
  - All channels read 0 before the first post-sweep update, and sat_flags=0.
- Asynchronous reset mid-SWEEP:
  - rst low between edges immediately forces out_valid=0, sat_flags=0 and in_ready=0.
  - After release, a 0x01 sample into any channel gives out_sum=0x0001.
